// File: rtl/lbd_bus_requester.sv
// ============================================================================
// Module   : lbd_bus_requester
// Desc     : CPU-side local BD bus initiator: request, synchronised grant,
//            address present, wait for ready, release. Clocked by OSC.
//            Optional macro LBD_LOCK_EN adds locked sequences (LOCKHOLD state).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lbd_bus_requester #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 16
) (
  input  logic              OSC,
  input  logic              MR,
  input  logic              REQ,
  input  logic              WR,
  input  logic              LOCK,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              TOUT,
  output logic [DATA_W-1:0] RDATA_OUT,
  output logic              BLRQ_n,
  input  logic              BGNT_n,
  output logic              BDAP_n,
  output logic              MWRITE_n,
  output logic              BLOCKL_n,
  output logic [ADDR_W-1:0] BA,
  output logic [DATA_W-1:0] BD_OUT,
  output logic              BD_OE_n,
  input  logic [DATA_W-1:0] BD_IN,
  input  logic              BDRY_n
);

  localparam logic [9:0] c_tout_limit = 10'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GNTWAIT  = 3'd1,
    S_ADDR1    = 3'd2,
    S_ADDR2    = 3'd3,
    S_WAITRDY  = 3'd4,
`ifdef LBD_LOCK_EN
    S_LOCKHOLD = 3'd6,
`endif
    S_RELEASE  = 3'd5
  } state_t;

  state_t              r_state;
  logic [1:0]          r_sync;      // [0] = first stage, [1] = synchronised grant
  logic [9:0]          r_cnt;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [9:0]          w_cnt_inc;
  logic                w_cnt_hit;

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 10'd1;
  assign w_cnt_hit = (w_cnt_inc == c_tout_limit);

`ifdef LBD_LOCK_EN
  logic r_lock;
  logic r_blockl_n;
  assign BLOCKL_n = r_blockl_n;
`else
  logic unused_lock;
  assign unused_lock = LOCK;
  assign BLOCKL_n    = 1'b1;
`endif

  always_ff @(posedge OSC or posedge MR) begin
    if (MR) begin
      r_state    <= S_IDLE;
      r_sync     <= 2'b11;
      r_cnt      <= '0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      TOUT       <= 1'b0;
      RDATA_OUT  <= '0;
      BLRQ_n     <= 1'b1;
      BDAP_n     <= 1'b1;
      MWRITE_n   <= 1'b1;
      BA         <= '0;
      BD_OUT     <= '0;
      BD_OE_n    <= 1'b1;
`ifdef LBD_LOCK_EN
      r_lock     <= 1'b0;
      r_blockl_n <= 1'b1;
`endif
    end else begin
      r_sync <= {r_sync[0], BGNT_n};
      DONE   <= 1'b0;
      TOUT   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (REQ) begin
            r_wr    <= WR;
            r_addr  <= ADDR;
            r_wdata <= WDATA;
`ifdef LBD_LOCK_EN
            r_lock  <= LOCK;
`endif
            r_cnt   <= '0;
            BLRQ_n  <= 1'b0;
            BUSY    <= 1'b1;
            r_state <= S_GNTWAIT;
          end
        end

        S_GNTWAIT: begin
          r_cnt <= w_cnt_inc;
          if (!r_sync[1]) begin
            BDAP_n     <= 1'b0;
            BA         <= r_addr;
            MWRITE_n   <= ~r_wr;
            BD_OE_n    <= ~r_wr;
            BD_OUT     <= r_wr ? r_wdata : '0;
`ifdef LBD_LOCK_EN
            r_blockl_n <= ~r_lock;
`endif
            r_state    <= S_ADDR1;
          end else if (w_cnt_hit) begin
            TOUT       <= 1'b1;
            BLRQ_n     <= 1'b1;
`ifdef LBD_LOCK_EN
            r_blockl_n <= 1'b1;
`endif
            r_state    <= S_RELEASE;
          end
        end

        // Fixed address setup; an early ready from the responder is not looked at here.
        S_ADDR1: r_state <= S_ADDR2;

        S_ADDR2: begin
          r_cnt   <= '0;
          r_state <= S_WAITRDY;
        end

        S_WAITRDY: begin
          r_cnt <= w_cnt_inc;
          if (!BDRY_n || w_cnt_hit) begin
            BDAP_n   <= 1'b1;
            MWRITE_n <= 1'b1;
            BD_OE_n  <= 1'b1;
            BA       <= '0;
            BD_OUT   <= '0;
          end
          if (!BDRY_n) begin
            DONE <= 1'b1;
            if (!r_wr) begin
              RDATA_OUT <= BD_IN;
            end
`ifdef LBD_LOCK_EN
            if (r_lock) begin
              r_cnt   <= '0;
              BUSY    <= 1'b0;
              r_state <= S_LOCKHOLD;
            end else begin
              BLRQ_n     <= 1'b1;
              r_blockl_n <= 1'b1;
              r_state    <= S_RELEASE;
            end
`else
            BLRQ_n  <= 1'b1;
            r_state <= S_RELEASE;
`endif
          end else if (w_cnt_hit) begin
            TOUT       <= 1'b1;
            BLRQ_n     <= 1'b1;
`ifdef LBD_LOCK_EN
            r_blockl_n <= 1'b1;
`endif
            r_state    <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          // Leave only once the responder has dropped both grant and ready.
          if (r_sync[1] && BDRY_n) begin
            BUSY    <= 1'b0;
            r_state <= S_IDLE;
          end
        end

`ifdef LBD_LOCK_EN
        S_LOCKHOLD: begin
          if (REQ) begin
            r_wr     <= WR;
            r_addr   <= ADDR;
            r_wdata  <= WDATA;
            r_lock   <= LOCK;
            BDAP_n   <= 1'b0;
            BA       <= ADDR;
            MWRITE_n <= ~WR;
            BD_OE_n  <= ~WR;
            BD_OUT   <= WR ? WDATA : '0;
            BUSY     <= 1'b1;
            r_state  <= S_ADDR1;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_hit) begin
              TOUT       <= 1'b1;
              BLRQ_n     <= 1'b1;
              r_blockl_n <= 1'b1;
              BUSY       <= 1'b1;
              r_state    <= S_RELEASE;
            end
          end
        end
`endif

        default: begin
          BUSY    <= 1'b0;
          BLRQ_n  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lbd_bus_requester.sv
// ============================================================================
// Module   : tb_lbd_bus_requester
// Desc     : Directed self-checking bench for lbd_bus_requester (TIMEOUT_CYCLES=8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lbd_bus_requester;

  logic        OSC = 1'b0;
  logic        MR  = 1'b1;
  logic        REQ = 1'b0;
  logic        WR  = 1'b0;
  logic        LOCK = 1'b0;
  logic [23:0] ADDR = '0;
  logic [15:0] WDATA = '0;
  logic        BUSY, DONE, TOUT;
  logic [15:0] RDATA_OUT;
  logic        BLRQ_n;
  logic        BGNT_n = 1'b1;
  logic        BDAP_n, MWRITE_n, BLOCKL_n, BD_OE_n;
  logic [23:0] BA;
  logic [15:0] BD_OUT;
  logic [15:0] BD_IN = '0;
  logic        BDRY_n = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  lbd_bus_requester #(.TIMEOUT_CYCLES(8), .ADDR_W(24), .DATA_W(16)) dut (
    .OSC(OSC), .MR(MR), .REQ(REQ), .WR(WR), .LOCK(LOCK), .ADDR(ADDR),
    .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .TOUT(TOUT),
    .RDATA_OUT(RDATA_OUT), .BLRQ_n(BLRQ_n), .BGNT_n(BGNT_n),
    .BDAP_n(BDAP_n), .MWRITE_n(MWRITE_n), .BLOCKL_n(BLOCKL_n), .BA(BA),
    .BD_OUT(BD_OUT), .BD_OE_n(BD_OE_n), .BD_IN(BD_IN), .BDRY_n(BDRY_n)
  );

  always #5 OSC = ~OSC;

  task automatic tick();
    @(posedge OSC);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    chk("rst_blrq",  32'(BLRQ_n),    32'd1);
    chk("rst_bdap",  32'(BDAP_n),    32'd1);
    chk("rst_mwr",   32'(MWRITE_n),  32'd1);
    chk("rst_oe",    32'(BD_OE_n),   32'd1);
    chk("rst_lock",  32'(BLOCKL_n),  32'd1);
    chk("rst_busy",  32'(BUSY),      32'd0);
    chk("rst_done",  32'(DONE),      32'd0);
    chk("rst_tout",  32'(TOUT),      32'd0);
    chk("rst_ba",    32'(BA),        32'd0);
    chk("rst_rdata", 32'(RDATA_OUT), 32'd0);
    MR = 1'b0;
    tick();

    // ---------------- read: grant low before edge 3, ready at edge 9 ----------------
    REQ = 1'b1; WR = 1'b0; ADDR = 24'h012345;
    tick();                                          // edge 0
    chk("rd_blrq_e0", 32'(BLRQ_n), 32'd0);
    chk("rd_busy_e0", 32'(BUSY),   32'd1);
    REQ = 1'b0;
    tick(); tick();                                  // edges 1,2
    BGNT_n = 1'b0;
    tick();                                          // edge 3
    chk("rd_bdap_e3", 32'(BDAP_n), 32'd1);
    tick();                                          // edge 4
    chk("rd_bdap_e4", 32'(BDAP_n), 32'd1);
    tick();                                          // edge 5
    chk("rd_bdap_e5", 32'(BDAP_n),   32'd0);
    chk("rd_ba_e5",   32'(BA),       32'h012345);
    chk("rd_mwr_e5",  32'(MWRITE_n), 32'd1);
    chk("rd_oe_e5",   32'(BD_OE_n),  32'd1);
    tick(); tick(); tick();                          // edges 6,7,8
    chk("rd_done_e8", 32'(DONE), 32'd0);
    BDRY_n = 1'b0; BD_IN = 16'hBEEF;
    tick();                                          // edge 9
    chk("rd_done_e9",  32'(DONE),      32'd1);
    chk("rd_tout_e9",  32'(TOUT),      32'd0);
    chk("rd_rdata_e9", 32'(RDATA_OUT), 32'h0000BEEF);
    chk("rd_bdap_e9",  32'(BDAP_n),    32'd1);
    chk("rd_ba_e9",    32'(BA),        32'd0);
    chk("rd_blrq_e9",  32'(BLRQ_n),    32'd1);
    BDRY_n = 1'b1; BGNT_n = 1'b1; BD_IN = 16'h0000;
    tick();                                          // edge 10
    chk("rd_done_e10", 32'(DONE), 32'd1 - 32'd1);
    tick();                                          // edge 11
    chk("rd_busy_e11", 32'(BUSY), 32'd1);
    tick();                                          // edge 12
    chk("rd_busy_e12", 32'(BUSY), 32'd0);

    // ---------------- write with early ready; REQ held during BUSY ----------------
    REQ = 1'b1; WR = 1'b1; ADDR = 24'h0000AA; WDATA = 16'h5A5A; BGNT_n = 1'b0;
    tick();                                          // edge 0
    tick();                                          // edge 1
    chk("wr_bdap_e1", 32'(BDAP_n), 32'd1);
    tick();                                          // edge 2
    chk("wr_bdap_e2", 32'(BDAP_n),   32'd0);
    chk("wr_mwr_e2",  32'(MWRITE_n), 32'd0);
    chk("wr_oe_e2",   32'(BD_OE_n),  32'd0);
    chk("wr_bdo_e2",  32'(BD_OUT),   32'h5A5A);
    chk("wr_ba_e2",   32'(BA),       32'h0000AA);
    BDRY_n = 1'b0;                                   // ready during ADDR1
    tick();                                          // edge 3
    chk("wr_early_e3", 32'(DONE), 32'd0);
    tick();                                          // edge 4
    chk("wr_early_e4", 32'(DONE),   32'd0);
    chk("wr_bdap_e4",  32'(BDAP_n), 32'd0);
    tick();                                          // edge 5
    chk("wr_done_e5",  32'(DONE),      32'd1);
    chk("wr_mwr_e5",   32'(MWRITE_n),  32'd1);
    chk("wr_oe_e5",    32'(BD_OE_n),   32'd1);
    chk("wr_bdap_e5",  32'(BDAP_n),    32'd1);
    chk("wr_rdata_e5", 32'(RDATA_OUT), 32'h0000BEEF);
    BDRY_n = 1'b1; BGNT_n = 1'b1;
    tick(); tick();                                  // edges 6,7: still releasing
    chk("b2b_busy_e7", 32'(BUSY),   32'd1);
    chk("b2b_blrq_e7", 32'(BLRQ_n), 32'd1);
    tick();                                          // edge 8: back to IDLE
    chk("b2b_busy_e8", 32'(BUSY),   32'd0);
    chk("b2b_blrq_e8", 32'(BLRQ_n), 32'd1);
    tick();                                          // edge 9: held REQ starts new cycle
    chk("b2b_blrq_e9", 32'(BLRQ_n), 32'd0);
    chk("b2b_busy_e9", 32'(BUSY),   32'd1);
    REQ = 1'b0;

    // ---------------- grant timeout (grant never given) ----------------
    for (int i = 10; i <= 16; i++) begin
      tick();
      chk("gto_bdap", 32'(BDAP_n), 32'd1);
      chk("gto_tout", 32'(TOUT),   32'd0);
    end
    tick();                                          // edge 17
    chk("gto_tout_e17", 32'(TOUT),   32'd1);
    chk("gto_done_e17", 32'(DONE),   32'd0);
    chk("gto_blrq_e17", 32'(BLRQ_n), 32'd1);
    chk("gto_bdap_e17", 32'(BDAP_n), 32'd1);
    tick();                                          // edge 18
    chk("gto_tout_e18", 32'(TOUT), 32'd0);
    chk("gto_busy_e18", 32'(BUSY), 32'd0);

    // ---------------- ready timeout ----------------
    REQ = 1'b1; WR = 1'b0; ADDR = 24'h111111; BGNT_n = 1'b0;
    tick();                                          // edge 0
    REQ = 1'b0;
    tick(); tick(); tick(); tick();                  // edges 1-4, WAITRDY entered at 4
    for (int i = 5; i <= 11; i++) tick();
    chk("rto_tout_e11", 32'(TOUT),   32'd0);
    chk("rto_bdap_e11", 32'(BDAP_n), 32'd0);
    tick();                                          // edge 12
    chk("rto_tout_e12",  32'(TOUT),      32'd1);
    chk("rto_done_e12",  32'(DONE),      32'd0);
    chk("rto_bdap_e12",  32'(BDAP_n),    32'd1);
    chk("rto_rdata_e12", 32'(RDATA_OUT), 32'h0000BEEF);
    BGNT_n = 1'b1;
    tick(); tick();                                  // edges 13,14
    chk("rto_busy_e14", 32'(BUSY), 32'd1);
    tick();                                          // edge 15
    chk("rto_busy_e15", 32'(BUSY), 32'd0);

    // ---------------- grant drop in WAITRDY, then reset abort ----------------
    REQ = 1'b1; WR = 1'b1; ADDR = 24'h222222; WDATA = 16'h1111; BGNT_n = 1'b0;
    tick();
    REQ = 1'b0;
    tick(); tick(); tick(); tick();                  // WAITRDY entered
    BGNT_n = 1'b1;
    tick(); tick(); tick();
    chk("gdrop_bdap", 32'(BDAP_n),  32'd0);
    chk("gdrop_oe",   32'(BD_OE_n), 32'd0);
    MR = 1'b1;
    #2;
    chk("mr_blrq", 32'(BLRQ_n),   32'd1);
    chk("mr_bdap", 32'(BDAP_n),   32'd1);
    chk("mr_mwr",  32'(MWRITE_n), 32'd1);
    chk("mr_oe",   32'(BD_OE_n),  32'd1);
    chk("mr_ba",   32'(BA),       32'd0);
    chk("mr_busy", 32'(BUSY),     32'd0);
    chk("mr_tout", 32'(TOUT),     32'd0);
    tick();
    MR = 1'b0;
    tick();

`ifdef LBD_LOCK_EN
    // ---------------- locked read followed by unlocked write ----------------
    REQ = 1'b1; WR = 1'b0; LOCK = 1'b1; ADDR = 24'h333333; BGNT_n = 1'b0;
    tick();                                          // edge 0
    REQ = 1'b0;
    tick(); tick();                                  // edge 2: ADDR1
    chk("lk_blockl_a1", 32'(BLOCKL_n), 32'd0);
    chk("lk_bdap_a1",   32'(BDAP_n),   32'd0);
    tick(); tick();                                  // edge 4: WAITRDY
    BDRY_n = 1'b0; BD_IN = 16'h1234;
    tick();                                          // edge 5: DONE, LOCKHOLD
    chk("lk_done1",   32'(DONE),      32'd1);
    chk("lk_rdata1",  32'(RDATA_OUT), 32'h1234);
    chk("lk_blrq_h",  32'(BLRQ_n),    32'd0);
    chk("lk_blockl_h", 32'(BLOCKL_n), 32'd0);
    chk("lk_busy_h",  32'(BUSY),      32'd0);
    BDRY_n = 1'b1; BGNT_n = 1'b1;
    REQ = 1'b1; WR = 1'b1; LOCK = 1'b0; ADDR = 24'h444444; WDATA = 16'hC3C3;
    tick();                                          // edge 6: straight to ADDR1
    chk("lk_bdap2",    32'(BDAP_n),   32'd0);
    chk("lk_ba2",      32'(BA),       32'h444444);
    chk("lk_mwr2",     32'(MWRITE_n), 32'd0);
    chk("lk_blockl2",  32'(BLOCKL_n), 32'd0);
    chk("lk_blrq2",    32'(BLRQ_n),   32'd0);
    REQ = 1'b0;
    tick(); tick();                                  // edge 8: WAITRDY
    BDRY_n = 1'b0;
    tick();                                          // edge 9
    chk("lk_done2",    32'(DONE),     32'd1);
    chk("lk_blockl_e", 32'(BLOCKL_n), 32'd1);
    chk("lk_blrq_e",   32'(BLRQ_n),   32'd1);
    BDRY_n = 1'b1;
    tick(); tick(); tick();
    chk("lk_busy_e",   32'(BUSY),     32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
